// File: rtl/soc_system_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture (W1C), IRQ mask
// and a level IRQ. Per-bit sync/edge/capture logic lives in the lane module.

module soc_system_pio_in_irq_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic armed,
  input  logic clr,
  output logic sync_bit,
  output logic cap_bit
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic cap_q, cap_d;
  logic rise, fall, edge_hit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall   = ~sync_q[SYNC_STAGES-1] & prev_q;
    case (EDGE_TYPE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
    // a fresh edge beats a same-cycle clear so no event is lost
    cap_d = (cap_q & ~clr) | (armed & edge_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cap_q  <= cap_d;
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign cap_bit  = cap_q;
endmodule

module soc_system_pio_in_irq #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int          EDGE_TYPE      = 0,
  parameter logic [31:0] IRQ_RESET_MASK = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [2:0]            warm_q, warm_d;
  logic                  armed, wr;
  logic [DATA_WIDTH-1:0] sync, cap, clr;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [31:0]           rd_q, rd_d;
  logic                  irq_q, irq_d;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr    = chipselect & ~write_n;
  assign armed = (warm_q == WARM_MAX);
  assign clr   = (wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    soc_system_pio_in_irq_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .armed   (armed),
      .clr     (clr[i]),
      .sync_bit(sync[i]),
      .cap_bit (cap[i])
    );
  end

  always_comb begin
    // edges stay blind until the synchroniser and prev hold real input data
    warm_d = armed ? warm_q : warm_q + 3'd1;
    mask_d = (wr && address == 2'd1) ? writedata[DATA_WIDTH-1:0] : mask_q;
    rd_d   = '0;
    case (address)
      2'd0:    rd_d[DATA_WIDTH-1:0] = sync;
      2'd1:    rd_d[DATA_WIDTH-1:0] = mask_q;
      2'd3:    rd_d[DATA_WIDTH-1:0] = cap;
      default: rd_d = '0;
    endcase
    irq_d = |(cap & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
      mask_q <= IRQ_RESET_MASK[DATA_WIDTH-1:0];
      rd_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
      irq_q  <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_soc_system_pio_in_irq.sv
// Bench for soc_system_pio_in_irq: three configurations share one bus; expected
// values are queued before each clock and compared just after it.

module tb_soc_system_pio_in_irq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, in_port;
  logic [31:0] rd0, rd2, rd8;
  logic        irq0, irq2, irq8;

  always #5 clk = ~clk;

  soc_system_pio_in_irq #(.DATA_WIDTH(32), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  soc_system_pio_in_irq #(.DATA_WIDTH(32), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  soc_system_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(1), .IRQ_RESET_MASK(32'h0F)) u8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd8), .irq(irq8));

  typedef struct {
    string       nm;
    int          inst;
    bit          is_irq;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       nm;
    bit          cs;
    bit          we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    int          inst;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[11];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] act_of(int inst, bit is_irq);
    case (inst)
      0:       return is_irq ? {31'b0, irq0} : rd0;
      2:       return is_irq ? {31'b0, irq2} : rd2;
      default: return is_irq ? {31'b0, irq8} : rd8;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic exp_rd(string nm, int inst, logic [31:0] v);
    sb.push_back('{nm, inst, 1'b0, v});
  endtask

  task automatic exp_irq(string nm, int inst, logic v);
    sb.push_back('{nm, inst, 1'b1, {31'b0, v}});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.nm, act_of(e.inst, e.is_irq), e.exp);
    end
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset(logic [31:0] pin);
    reset_n = 1'b0; in_port = pin; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{"mask_rst8",  1'b1, 1'b0, 2'd0, 32'h0,         2'd1, 8, 32'h0000_000F};
    tbl[1]  = '{"mask_rst32", 1'b1, 1'b0, 2'd0, 32'h0,         2'd1, 0, 32'h0};
    tbl[2]  = '{"mask_wr8",   1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 8, 32'h0000_00FF};
    tbl[3]  = '{"mask_wr32",  1'b1, 1'b0, 2'd0, 32'h0,         2'd1, 0, 32'hFFFF_FFFF};
    tbl[4]  = '{"rsv_rd32",   1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 0, 32'h0};
    tbl[5]  = '{"rsv_rd8",    1'b1, 1'b0, 2'd0, 32'h0,         2'd2, 8, 32'h0};
    tbl[6]  = '{"wr_a0_ign",  1'b1, 1'b1, 2'd0, 32'h0,         2'd0, 8, 32'h0000_00A5};
    tbl[7]  = '{"in_rd32",    1'b1, 1'b0, 2'd0, 32'h0,         2'd0, 0, 32'h0000_00A5};
    tbl[8]  = '{"cs_gate",    1'b0, 1'b1, 2'd1, 32'h0,         2'd1, 8, 32'h0000_00FF};
    tbl[9]  = '{"mask_clr",   1'b1, 1'b1, 2'd1, 32'h0,         2'd1, 0, 32'h0};
    tbl[10] = '{"cap_idle",   1'b1, 1'b0, 2'd0, 32'h0,         2'd3, 2, 32'h0};

    // reset with inputs high: latency of sync readback, no spurious capture
    do_reset(32'hFFFF_FFFF);
    cyc();
    exp_rd("sync_pre", 0, 32'h0);
    cyc();
    exp_rd("sync_lat", 0, 32'hFFFF_FFFF);
    exp_rd("sync_lat8", 8, 32'h0000_00FF);
    cyc();
    run(7);
    address = 2'd3;
    exp_rd("warm_cap0", 0, 32'h0);
    exp_rd("warm_cap2", 2, 32'h0);
    exp_irq("warm_irq0", 0, 1'b0);
    exp_irq("warm_irq2", 2, 1'b0);
    cyc();

    // rising edge on bit 0, irq latency, W1C
    do_reset(32'h0);
    run(6);
    bus_wr(2'd1, 32'h1);
    address = 2'd3;
    in_port = 32'h1;
    cyc(); cyc();
    exp_irq("irq_early", 0, 1'b0);
    cyc();
    exp_rd("cap_set", 0, 32'h1);
    exp_irq("irq_set", 0, 1'b1);
    cyc();
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    exp_irq("irq_hold", 0, 1'b1);
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    exp_irq("irq_clr", 0, 1'b0);
    exp_rd("cap_clr", 0, 32'h0);
    cyc();

    // W1C of bit 5 in the same cycle as its capture: set wins
    in_port = 32'h21;
    cyc(); cyc();
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h20;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    exp_rd("collide", 0, 32'h20);
    exp_rd("collide_any", 2, 32'h20);
    cyc();
    bus_wr(2'd3, 32'h20);
    exp_rd("w1c5", 0, 32'h0);
    cyc();

    // 5-cycle pulse on bit 7 across edge types, mask gating of irq
    do_reset(32'h0);
    run(6);
    bus_wr(2'd1, 32'h0);
    address = 2'd3;
    in_port = 32'h80;
    run(3);
    exp_rd("rise7_any", 2, 32'h80);
    exp_rd("rise7_r", 0, 32'h80);
    exp_rd("rise7_f", 8, 32'h0);
    cyc();
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h80;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    in_port = 32'h0;
    exp_rd("clr7", 2, 32'h0);
    cyc();
    cyc(); cyc();
    exp_rd("fall7_any", 2, 32'h80);
    exp_rd("fall7_r", 0, 32'h0);
    exp_rd("fall7_f", 8, 32'h80);
    exp_irq("irq_mask0", 2, 1'b0);
    cyc();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h80;
    exp_irq("irq_mask_lag", 2, 1'b0);
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    exp_irq("irq_mask1", 2, 1'b1);
    exp_irq("irq_mask1_f", 8, 1'b1);
    exp_irq("irq_mask1_r", 0, 1'b0);
    cyc();

    // register map, width truncation, ignored writes
    do_reset(32'h0000_00A5);
    run(6);
    foreach (tbl[i]) begin
      chipselect = tbl[i].cs; write_n = ~tbl[i].we;
      address = tbl[i].waddr; writedata = tbl[i].wdata;
      cyc();
      chipselect = 1'b0; write_n = 1'b1; address = tbl[i].raddr;
      exp_rd(tbl[i].nm, tbl[i].inst, tbl[i].exp);
      cyc();
    end

    // async reset mid-operation, warm-up restarts with inputs held high
    do_reset(32'h0);
    run(6);
    bus_wr(2'd1, 32'h3);
    address = 2'd3;
    in_port = 32'h3;
    run(4);
    exp_rd("pre_rst_cap", 0, 32'h3);
    exp_irq("pre_rst_irq", 0, 1'b1);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("async_rd", rd0, 32'h0);
    chk("async_irq", {31'b0, irq0}, 32'h0);
    cyc(); cyc();
    reset_n = 1'b1;
    run(10);
    exp_rd("rewarm_cap", 0, 32'h0);
    exp_rd("rewarm_cap2", 2, 32'h0);
    exp_irq("rewarm_irq", 0, 1'b0);
    cyc();
    address = 2'd1;
    exp_rd("rst_mask", 0, 32'h0);
    exp_rd("rst_mask8", 8, 32'h0000_000F);
    cyc();
    address = 2'd0;
    exp_rd("rst_sync", 0, 32'h3);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
